// File: rtl/delay_glide_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : delay_glide_ctrl_pkg
// Description : Shared audio-path types and constants for the delay glide
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package delay_glide_ctrl_pkg;

    localparam int DEFAULT_DELAY_WIDTH = 12;
    localparam int DEFAULT_GAIN_WIDTH  = 8;

    localparam logic [DEFAULT_GAIN_WIDTH-1:0] GAIN_UNITY = '1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RAMP     = 3'd1,
        FADE_OUT = 3'd2,
        JUMP     = 3'd3,
        SETTLE   = 3'd4,
        FADE_IN  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/delay_glide_ctrl_fader.sv
`default_nettype none
// ============================================================================
// Module      : gain_fader
// Description : Saturating up/down gain counter, advanced on an enable strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module gain_fader #(
    parameter int                    GAIN_WIDTH = 8,
    parameter logic [GAIN_WIDTH-1:0] UNITY      = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_up,
    input  logic [GAIN_WIDTH-1:0] i_step,
    output logic [GAIN_WIDTH-1:0] o_gain,
    output logic                  o_zero,
    output logic                  o_unity
);

    localparam logic [GAIN_WIDTH:0] c_ceiling = {1'b0, UNITY};

    logic [GAIN_WIDTH-1:0] r_gain;
    logic [GAIN_WIDTH-1:0] w_gain_nxt;
    logic [GAIN_WIDTH:0]   w_sum;
    logic [GAIN_WIDTH:0]   w_dif;

    always_comb begin
        w_sum      = {1'b0, r_gain} + {1'b0, i_step};
        w_dif      = {1'b0, r_gain} - {1'b0, i_step};
        w_gain_nxt = r_gain;
        if (i_en) begin
            if (i_up) begin
                w_gain_nxt = (w_sum > c_ceiling) ? UNITY : w_sum[GAIN_WIDTH-1:0];
            end else begin
                w_gain_nxt = w_dif[GAIN_WIDTH] ? '0 : w_dif[GAIN_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gain <= UNITY;
        end else begin
            r_gain <= w_gain_nxt;
        end
    end

    // Flags describe the value being loaded at this edge, so the caller can
    // leave its fade state on the same edge the limit is reached.
    assign o_gain  = r_gain;
    assign o_zero  = (w_gain_nxt == '0);
    assign o_unity = (w_gain_nxt == UNITY);

endmodule
`default_nettype wire

// File: rtl/delay_glide_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : delay_glide_ctrl
// Description : Drives a variable delay line click-free: small changes glide,
//               large changes fade out, jump, settle and fade back in.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_glide_ctrl
    import delay_glide_ctrl_pkg::*;
#(
    parameter int DELAY_WIDTH = DEFAULT_DELAY_WIDTH,
    parameter int GAIN_WIDTH  = DEFAULT_GAIN_WIDTH,
    parameter int RAMP_LIMIT  = 64,
    parameter int STEP_DIV    = 4,
    parameter int FADE_STEP   = 16,
    parameter int SETTLE_MIN  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_en,
    input  logic                   cfg_valid,
    input  logic [DELAY_WIDTH-1:0] cfg_delay,
    output logic                   cfg_ready,
    output logic [DELAY_WIDTH-1:0] delay_out,
    output logic [GAIN_WIDTH-1:0]  gain_out,
    output logic                   busy,
    output logic                   done
);

    localparam int                     c_step_w     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [c_step_w-1:0]    c_step_last  = c_step_w'(STEP_DIV - 1);
    localparam logic [DELAY_WIDTH:0]   c_ramp_limit = (DELAY_WIDTH + 1)'(RAMP_LIMIT);
    localparam logic [DELAY_WIDTH-1:0] c_settle_min = DELAY_WIDTH'(SETTLE_MIN);
    localparam logic [GAIN_WIDTH-1:0]  c_fade_step  = GAIN_WIDTH'(FADE_STEP);
    localparam logic [GAIN_WIDTH-1:0]  c_gain_unity =
        (GAIN_WIDTH == DEFAULT_GAIN_WIDTH) ? GAIN_WIDTH'(GAIN_UNITY) : {GAIN_WIDTH{1'b1}};

    state_t                  r_state, w_state_nxt;
    logic [DELAY_WIDTH-1:0]  r_delay, w_delay_nxt;
    logic [DELAY_WIDTH-1:0]  r_target, w_target_nxt;
    logic [DELAY_WIDTH-1:0]  r_settle, w_settle_nxt;
    logic [c_step_w-1:0]     r_step, w_step_nxt;
    logic                    r_up, w_up_nxt;
    logic                    r_done, w_done_nxt;
    logic signed [DELAY_WIDTH:0] w_diff;
    logic [DELAY_WIDTH:0]    w_mag;
    logic                    w_fade_en, w_fade_up, w_gain_zero, w_gain_unity;

    // Only consulted while IDLE, where the incoming request is the new target.
    assign w_diff    = $signed({1'b0, cfg_delay}) - $signed({1'b0, r_delay});
    assign w_mag     = w_diff[DELAY_WIDTH] ? (DELAY_WIDTH + 1)'(-w_diff) : (DELAY_WIDTH + 1)'(w_diff);
    assign w_fade_en = sample_en && ((r_state == FADE_OUT) || (r_state == FADE_IN));
    assign w_fade_up = (r_state == FADE_IN);

    gain_fader #(
        .GAIN_WIDTH (GAIN_WIDTH),
        .UNITY      (c_gain_unity)
    ) u_gain_fader (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_fade_en),
        .i_up    (w_fade_up),
        .i_step  (c_fade_step),
        .o_gain  (gain_out),
        .o_zero  (w_gain_zero),
        .o_unity (w_gain_unity)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_delay_nxt  = r_delay;
        w_target_nxt = r_target;
        w_settle_nxt = r_settle;
        w_step_nxt   = r_step;
        w_up_nxt     = r_up;
        w_done_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_valid) begin
                    w_target_nxt = cfg_delay;
                    w_up_nxt     = !w_diff[DELAY_WIDTH];
                    w_step_nxt   = '0;
                    if (w_diff == '0) begin
                        w_done_nxt = 1'b1;
                    end else if (w_mag <= c_ramp_limit) begin
                        w_state_nxt = RAMP;
                    end else begin
                        w_state_nxt = FADE_OUT;
                    end
                end
            end
            RAMP: begin
                if (sample_en) begin
                    if (r_step == c_step_last) begin
                        w_step_nxt  = '0;
                        w_delay_nxt = r_up ? r_delay + 1'b1 : r_delay - 1'b1;
                        if (w_delay_nxt == r_target) begin
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_step_nxt = r_step + 1'b1;
                    end
                end
            end
            FADE_OUT: begin
                if (sample_en && w_gain_zero) begin
                    w_state_nxt = JUMP;
                end
            end
            JUMP: begin
                // A longer delay needs the line to refill before it is audible.
                w_delay_nxt  = r_target;
                w_settle_nxt = (r_target > r_delay) ? r_target : c_settle_min;
                w_state_nxt  = SETTLE;
            end
            SETTLE: begin
                if (r_settle == '0) begin
                    w_state_nxt = FADE_IN;
                end else if (sample_en) begin
                    w_settle_nxt = r_settle - 1'b1;
                    if (r_settle == DELAY_WIDTH'(1)) begin
                        w_state_nxt = FADE_IN;
                    end
                end
            end
            FADE_IN: begin
                if (sample_en && w_gain_unity) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_delay  <= '0;
            r_target <= '0;
            r_settle <= '0;
            r_step   <= '0;
            r_up     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_delay  <= w_delay_nxt;
            r_target <= w_target_nxt;
            r_settle <= w_settle_nxt;
            r_step   <= w_step_nxt;
            r_up     <= w_up_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign cfg_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign delay_out = r_delay;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_delay_glide_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_delay_glide_ctrl
// Description : Self-checking bench for delay_glide_ctrl against a phase-level
//               behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_glide_ctrl;

    localparam int DW         = 12;
    localparam int GW         = 8;
    localparam int RAMP_LIMIT = 64;
    localparam int STEP_DIV   = 4;
    localparam int FADE_STEP  = 16;
    localparam int SETTLE_MIN = 2;
    localparam int UNITY      = 255;

    localparam int PH_IDLE = 0, PH_RAMP = 1, PH_FADE_OUT = 2, PH_JUMP = 3, PH_SETTLE = 4, PH_FADE_IN = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_en = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [DW-1:0] cfg_delay = '0;
    logic          cfg_ready;
    logic [DW-1:0] delay_out;
    logic [GW-1:0] gain_out;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    delay_glide_ctrl #(
        .DELAY_WIDTH (DW),
        .GAIN_WIDTH  (GW),
        .RAMP_LIMIT  (RAMP_LIMIT),
        .STEP_DIV    (STEP_DIV),
        .FADE_STEP   (FADE_STEP),
        .SETTLE_MIN  (SETTLE_MIN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .cfg_valid (cfg_valid),
        .cfg_delay (cfg_delay),
        .cfg_ready (cfg_ready),
        .delay_out (delay_out),
        .gain_out  (gain_out),
        .busy      (busy),
        .done      (done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Model: phase plus strobe count k since the phase began; outputs are
    // closed-form functions of k.
    int m_phase = PH_IDLE;
    int m_delay = 0, m_gain = UNITY, m_target = 0, m_start = 0, m_k = 0, m_settle_len = 0, m_done = 0;

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_edge(bit r, bit se, bit v, int d);
        m_done = 0;
        if (r) begin
            m_phase = PH_IDLE; m_delay = 0; m_gain = UNITY; m_target = 0; m_k = 0;
            return;
        end
        case (m_phase)
            PH_IDLE: if (v) begin
                m_target = d;
                if (d == m_delay) m_done = 1;
                else begin
                    m_start = m_delay;
                    m_k     = 0;
                    m_phase = ((d > m_delay ? d - m_delay : m_delay - d) <= RAMP_LIMIT) ? PH_RAMP : PH_FADE_OUT;
                end
            end
            PH_RAMP: if (se) begin
                m_k++;
                m_delay = m_start + ((m_target > m_start) ? 1 : -1) * (m_k / STEP_DIV);
                if (m_delay == m_target) begin m_phase = PH_IDLE; m_done = 1; end
            end
            PH_FADE_OUT: if (se) begin
                m_k++;
                m_gain = (UNITY - FADE_STEP * m_k > 0) ? UNITY - FADE_STEP * m_k : 0;
                if (m_gain == 0) m_phase = PH_JUMP;
            end
            PH_JUMP: begin
                m_settle_len = (m_target > m_delay) ? m_target : SETTLE_MIN;
                m_delay = m_target;
                m_k     = 0;
                m_phase = PH_SETTLE;
            end
            PH_SETTLE: begin
                if (m_k == m_settle_len) begin m_phase = PH_FADE_IN; m_k = 0; end
                else if (se) begin
                    m_k++;
                    if (m_k == m_settle_len) begin m_phase = PH_FADE_IN; m_k = 0; end
                end
            end
            PH_FADE_IN: if (se) begin
                m_k++;
                m_gain = (FADE_STEP * m_k < UNITY) ? FADE_STEP * m_k : UNITY;
                if (m_gain == UNITY) begin m_phase = PH_IDLE; m_done = 1; end
            end
            default: m_phase = PH_IDLE;
        endcase
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("delay_out", int'(delay_out), m_delay);
            chk("gain_out",  int'(gain_out),  m_gain);
            chk("busy",      int'(busy),      int'(m_phase != PH_IDLE));
            chk("done",      int'(done),      m_done);
            chk("cfg_ready", int'(cfg_ready), int'(m_phase == PH_IDLE));
        end
    end

    task automatic step(bit r, bit se, bit v, int d);
        rst = r; sample_en = se; cfg_valid = v; cfg_delay = DW'(d);
        @(posedge clk);
        model_edge(r, se, v, d);
        @(negedge clk);
    endtask

    task automatic go(int d, int period, int bound, output int strobes, output int dones);
        bit seen;
        bit se;
        int c;
        strobes = 0; dones = 0; c = 0;
        step(0, 0, 1, d);
        seen  = done;
        dones = int'(done);
        while (!seen && c < bound) begin
            se = ((c % period) == (period - 1));
            step(0, se, 0, 0);
            strobes += int'(se);
            if (done) begin seen = 1; dones++; end
            c++;
        end
        if (!seen) chk("timeout_go", 0, 1);
        repeat (2) begin step(0, 0, 0, 0); dones += int'(done); end
    endtask

    task automatic wait_done(int bound);
        bit seen = 0;
        for (int c = 0; c < bound && !seen; c++) begin
            step(0, 1, 0, 0);
            if (done) seen = 1;
        end
        if (!seen) chk("timeout_wait", 0, 1);
    endtask

    initial begin
        int s, dn, d;
        bit seen;
        step(1, 0, 0, 0);
        chk_en = 1'b1;
        chk("rst_delay", int'(delay_out), 0);
        chk("rst_gain",  int'(gain_out),  255);
        chk("rst_ready", int'(cfg_ready), 1);
        chk("rst_busy",  int'(busy),      0);
        chk("rst_done",  int'(done),      0);

        // Glide up 0 -> 10, strobe every 8 clk
        go(10, 8, 1000, s, dn);
        chk("glide_strobes", s, 40);
        chk("glide_dones",   dn, 1);
        chk("glide_delay",   int'(delay_out), 10);
        chk("glide_gain",    int'(gain_out), 255);

        // Request held while busy; taken on the first IDLE cycle
        step(0, 0, 1, 30);
        seen = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            step(0, 1, 1, 20);
            if (busy) chk("ready_while_busy", int'(cfg_ready), 0);
            if (done) seen = 1;
        end
        chk("hold_reached30", int'(delay_out), 30);
        step(0, 1, 1, 20);
        chk("accepted_first_idle", int'(busy), 1);
        wait_done(400);
        chk("hold_reached20", int'(delay_out), 20);

        // Same-value request
        go(20, 1, 10, s, dn);
        chk("same_dones",   dn, 1);
        chk("same_strobes", s, 0);
        chk("same_delay",   int'(delay_out), 20);

        // Stall mid-RAMP
        step(0, 0, 1, 25);
        repeat (3) step(0, 1, 0, 0);
        repeat (100) step(0, 0, 0, 0);
        chk("stall_delay", int'(delay_out), 20);
        step(0, 1, 0, 0);
        chk("stall_resume", int'(delay_out), 21);
        wait_done(200);

        // Large increase and decrease
        go(1000, 2, 5000, s, dn);
        chk("inc_strobes", s, 1032);
        chk("inc_dones",   dn, 1);
        chk("inc_delay",   int'(delay_out), 1000);
        chk("inc_gain",    int'(gain_out), 255);
        go(5, 2, 500, s, dn);
        chk("dec_strobes", s, 34);
        chk("dec_delay",   int'(delay_out), 5);

        // Reset mid FADE_OUT
        step(0, 0, 1, 900);
        repeat (10) step(0, 1, 0, 0);
        chk("midfade_gain", int'(gain_out), 95);
        step(1, 0, 0, 0);
        chk("mrst_delay", int'(delay_out), 0);
        chk("mrst_gain",  int'(gain_out),  255);
        chk("mrst_ready", int'(cfg_ready), 1);
        chk("mrst_busy",  int'(busy),      0);
        chk("mrst_done",  int'(done),      0);

        // Randomized traffic
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 4) == 0) d = $urandom_range(0, 600);
            else d = m_delay + $urandom_range(0, 160) - 80;
            if (d < 0) d = 0;
            if (d > 4095) d = 4095;
            step($urandom_range(0, 499) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
